// File: rtl/muldiv_seq.sv
// Multi-cycle 32-bit multiply/divide sequencer sharing one carry-lookahead adder (add_32).
// Define MULDIV_DIV_EN to build the restoring divider; without it every DIV request completes with err=1.
`timescale 1ns/1ps

module add_32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    // 4-bit lookahead groups; the group generate/propagate terms skip the carry past each nibble.
    always_comb begin : cla
        logic [31:0] g;
        logic [31:0] p;
        logic        gcar;
        logic        bcar;
        logic        grp_g;
        logic        grp_p;
        g    = x & y;
        p    = x ^ y;
        gcar = cin;
        sum  = '0;
        for (int k = 0; k < 8; k++) begin
            grp_g = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p = &p[4*k +: 4];
            bcar  = gcar;
            for (int j = 0; j < 4; j++) begin
                sum[4*k+j] = p[4*k+j] ^ bcar;
                bcar       = g[4*k+j] | (p[4*k+j] & bcar);
            end
            gcar = grp_g | (grp_p & gcar);
        end
        cout = gcar;
    end
endmodule

module muldiv_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         err
);
    typedef enum logic [2:0] {
        IDLE, ABS_A, ABS_B, RUN, FIX_LO, FIX_HI, DONE
    } state_t;

    localparam int CW = $clog2(N);

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  hi_q, hi_d;
    logic [N-1:0]  lo_q, lo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sgn_q, sgn_d;
    logic          div_q, div_d;
    logic          pneg_q, pneg_d;
    logic          carry_q, carry_d;
    logic          err_q, err_d;
`ifdef MULDIV_DIV_EN
    logic          rneg_q, rneg_d;
    logic          msb;
    logic [N-1:0]  rem_sh;
    logic [N-1:0]  quo_sh;
`endif

    logic [N-1:0]  add_x, add_y, add_s;
    logic          add_ci, add_co;

    add_32 u_add (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_ci),
        .sum  (add_s),
        .cout (add_co)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        div_d   = div_q;
        pneg_d  = pneg_q;
        carry_d = carry_q;
        err_d   = err_q;
`ifdef MULDIV_DIV_EN
        rneg_d  = rneg_q;
        msb     = 1'b0;
        rem_sh  = '0;
        quo_sh  = '0;
`endif
        add_x   = '0;
        add_y   = '0;
        add_ci  = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = op[1];
                    div_d   = op[0];
                    pneg_d  = op[1] & (a[N-1] ^ b[N-1]);
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ABS_A;
`ifdef MULDIV_DIV_EN
                    rneg_d  = op[1] & a[N-1];
                    if (op[0] && (b == '0)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        hi_d    = a;
                        lo_d    = '1;
                    end
`else
                    if (op[0]) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        hi_d    = '0;
                        lo_d    = '0;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end

            ABS_A: begin
                if (sgn_q && a_q[N-1]) begin
                    add_x  = ~a_q;
                    add_ci = 1'b1;
                    a_d    = add_s;
                end
                state_d = ABS_B;
            end

            ABS_B: begin
                if (sgn_q && b_q[N-1]) begin
                    add_x  = ~b_q;
                    add_ci = 1'b1;
                    b_d    = add_s;
                end
                // Seed {hi,lo}: MUL shifts the multiplier out of lo, DIV shifts the dividend out of lo.
                hi_d    = '0;
                lo_d    = div_q ? a_q : b_d;
                state_d = RUN;
            end

            RUN: begin
                if (div_q) begin
`ifdef MULDIV_DIV_EN
                    msb    = hi_q[N-1];
                    rem_sh = {hi_q[N-2:0], lo_q[N-1]};
                    quo_sh = {lo_q[N-2:0], 1'b0};
                    add_x  = rem_sh;
                    add_y  = ~b_q;
                    add_ci = 1'b1;
                    // msb covers a shifted remainder that no longer fits in N bits.
                    if (msb | add_co) begin
                        hi_d = add_s;
                        lo_d = {quo_sh[N-1:1], 1'b1};
                    end else begin
                        hi_d = rem_sh;
                        lo_d = quo_sh;
                    end
`endif
                end else begin
                    if (lo_q[0]) begin
                        add_x = hi_q;
                        add_y = a_q;
                        hi_d  = {add_co, add_s[N-1:1]};
                        lo_d  = {add_s[0], lo_q[N-1:1]};
                    end else begin
                        hi_d  = {1'b0, hi_q[N-1:1]};
                        lo_d  = {hi_q[0], lo_q[N-1:1]};
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = FIX_LO;
                end
            end

            FIX_LO: begin
                if (pneg_q) begin
                    add_x   = ~lo_q;
                    add_ci  = 1'b1;
                    lo_d    = add_s;
                    carry_d = add_co;
                end
                state_d = FIX_HI;
            end

            FIX_HI: begin
                if (div_q) begin
`ifdef MULDIV_DIV_EN
                    if (rneg_q) begin
                        add_x  = ~hi_q;
                        add_ci = 1'b1;
                        hi_d   = add_s;
                    end
`endif
                end else if (pneg_q) begin
                    // Upper half of the 64-bit negate takes the carry out of the lower half.
                    add_x  = ~hi_q;
                    add_ci = carry_q;
                    hi_d   = add_s;
                end
                state_d = DONE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            div_q   <= 1'b0;
            pneg_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            rneg_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            div_q   <= div_d;
            pneg_q  <= pneg_d;
            carry_q <= carry_d;
            err_q   <= err_d;
`ifdef MULDIV_DIV_EN
            rneg_q  <= rneg_d;
`endif
        end
    end

    always_comb begin
        busy = (state_q != IDLE) && (state_q != DONE);
        done = (state_q == DONE);
        hi   = hi_q;
        lo   = lo_q;
        err  = err_q;
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: arithmetic reference model with per-cycle compare plus directed literal vectors.
// Expectations for DIV follow whether MULDIV_DIV_EN is defined for the build.
`timescale 1ns/1ps

module tb_muldiv_seq;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    localparam logic [1:0] MULU = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] MULS = 2'b10;
    localparam logic [1:0] DIVS = 2'b11;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, err;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_seq #(.N(32)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .err   (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {hi, lo, err} from the operands alone.
    function automatic logic [64:0] model_result(input logic [1:0] o, input logic [31:0] va,
                                                 input logic [31:0] vb);
        logic signed [63:0] sa, sb, r, q, m;
        sa = o[1] ? {{32{va[31]}}, va} : {32'h0, va};
        sb = o[1] ? {{32{vb[31]}}, vb} : {32'h0, vb};
        if (!o[0]) begin
            r = sa * sb;
            return {r, 1'b0};
        end
        if (!DIV_ON) return {64'h0, 1'b1};
        if (vb == 32'h0) return {va, 32'hFFFF_FFFF, 1'b1};
        q = sa / sb;
        m = sa % sb;
        return {m[31:0], q[31:0], 1'b0};
    endfunction

    function automatic bit model_short(input logic [1:0] o, input logic [31:0] vb);
        return o[0] && (!DIV_ON || vb == 32'h0);
    endfunction

    // Model timeline: m_left counts edges until done appears; visible results move at done.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_err = 1'b0;
    logic [64:0] pend = '0;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_err  <= 1'b0;
        end else if (start && m_left == 0) begin
            if (model_short(op, b)) begin
                {m_hi, m_lo, m_err} <= model_result(op, a, b);
                m_done <= 1'b1;
            end else begin
                pend   <= model_result(op, a, b);
                m_left <= 36;
                m_done <= 1'b0;
                m_err  <= 1'b0;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                {m_hi, m_lo, m_err} <= pend;
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_busy", busy, m_left > 0);
            check("cmp_done", done, m_done);
            check("cmp_err", err, m_err);
            if (m_left == 0) begin
                check("cmp_hi", hi, m_hi);
                check("cmp_lo", lo, m_lo);
            end
        end
    end

    // Issues one op, scrambles the inputs after accept, optionally pulses start mid-op,
    // waits (bounded) for done and checks latency and results against literals.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] eh, input logic [31:0] el,
                          input logic ee, input int elat, input int noise_at);
        int n;
        op = o;
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~va;
        b = 32'hDEAD_BEEF;
        op = ~o;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            start = (n == noise_at);
        end
        start = 1'b0;
        check({name, "_latency"}, n + 1, elat);
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
        check({name, "_err"}, err, ee);
    endtask

    // DIV vectors: literal values for the divider build, the error response otherwise.
    task automatic run_div(input string name, input logic [1:0] o, input logic [31:0] va,
                           input logic [31:0] vb, input logic [31:0] eh, input logic [31:0] el,
                           input logic ee, input int elat);
        if (DIV_ON) run_op(name, o, va, vb, eh, el, ee, elat, -1);
        else        run_op(name, o, va, vb, 32'h0, 32'h0, 1'b1, 1, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        chk_en = 1'b1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        run_op("mulu_max", MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 37, -1);
        run_op("muls_m3_7", MULS, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 37, 10);
        run_op("mulu_6_7", MULU, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, 37, 5);
        repeat (3) @(posedge clk);
        #1;
        run_op("muls_min_min", MULS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 37, -1);
        run_op("muls_max_m1", MULS, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 37, -1);
        run_op("muls_m5_0", MULS, 32'hFFFF_FFFB, 32'h0, 32'h0, 32'h0, 1'b0, 37, -1);
        run_op("muls_m1_m1", MULS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 37, -1);

        run_div("divs_m7_2", DIVS, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 37);
        run_div("divu_max_msb", DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1'b0, 37);
        run_div("divu_by0", DIVU, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1);
        run_div("divs_min_m1", DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 37);
        run_div("divu_10_3", DIVU, 32'd10, 32'd3, 32'd1, 32'd3, 1'b0, 37);
        repeat (2) @(posedge clk);
        #1;
        run_div("divs_7_m2", DIVS, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 37);
        run_div("divs_m8_m3", DIVS, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2, 1'b0, 37);
        run_op("mulu_after_div", MULU, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 1'b0, 37, -1);

        // Abort a multiply 20 cycles in.
        repeat (2) @(posedge clk);
        #1;
        op = MULU;
        a = 32'h1234_5678;
        b = 32'h9ABC_DEF0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("preclr_busy", busy, 1'b1);
        clr = 1'b1;
        #1;
        check("clr_busy", busy, 1'b0);
        check("clr_done", done, 1'b0);
        check("clr_hi", hi, 32'h0);
        check("clr_lo", lo, 32'h0);
        check("clr_err", err, 1'b0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        run_op("mul_after_clr", MULU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 32'h242D_2080, 1'b0, 37, 12);
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle multiply/divide sequencer for the integer datapath. It drives a single instance of the shared 32-bit carry-lookahead adder (`add_32`) as its only arithmetic resource. Radix-2 shift-add multiply and restoring divide run in 32 iterations, and results go to the HI/LO register pair. It sits beside the ALU and is started by the control unit for MUL/DIV instructions.

## Interface
- `N`, 32: operand width. Only 32 is supported because the adder is fixed at 32 bits.
- `clk` in 1: clock. All state updates on the rising edge.
- `clr` in 1: asynchronous, active-high reset.
- `start` in 1: request. Sampled only when idle.
- `op` in 2: `op[0]`: 0 = MUL, 1 = DIV. `op[1]`: 1 = signed, 0 = unsigned.
- `a` in 32: multiplicand or dividend. Captured at accept.
- `b` in 32: multiplier or divisor. Captured at accept.
- `busy` out 1: high from the cycle after accept until the cycle before `done`.
- `done` out 1: one-cycle pulse. `hi`/`lo`/`err` are valid from this cycle.
- `hi` out 32: MUL: product[63:32]. DIV: remainder.
- `lo` out 32: MUL: product[31:0]. DIV: quotient.
- `err` out 1: divide-by-zero, or DIV requested with divide compiled out. Held with the results.

## Operation
**States:** IDLE, ABS_A, ABS_B, RUN, FIX_LO, FIX_HI, DONE.

**Accept:**
- `start` in IDLE or DONE captures `a`, `b` and `op`.
- It also latches the sign flags:
  - `pneg` = `a[31]` ^ `b[31]`
  - `rneg` = `a[31]`
  - Both flags are 0 when unsigned.
- It clears the step counter and moves to ABS_A.
- `start` in any other state is ignored.

**ABS_A / ABS_B:**
- Each state replaces its operand with the magnitude via adder (`~x` + 1) when signed and negative. Otherwise it holds the operand.
- One cycle each, always, so latency is fixed.

**Divide-by-zero:**
- DIV with `b` = 0 goes IDLE/DONE → DONE directly.
- Outputs: `err`=1, `lo`=`32'hFFFFFFFF`, `hi`=`a` (raw, unsigned).

**RUN (32 cycles):**
- MUL:
  - `{hi,lo}` starts as {0, |b|}.
  - Each step computes `add_32(hi, |a|, 0)` only when `lo[0]`=1.
  - Then `{cout_or_0, hi, lo}` shifts right 1.
- DIV:
  - `{rem,quo}` starts as {0, |a|}.
  - Each step shifts left 1, keeping the bit shifted out of `rem` (`msb`).
  - Trial subtraction is `add_32(rem, ~|b|, 1)`.
  - If `msb` | `Cout`: `rem` takes the trial result and the quotient LSB is 1. Otherwise `rem` is kept and the LSB is 0.

**FIX_LO / FIX_HI (one cycle each, always):**
- MUL with `pneg`:
  - FIX_LO: `lo` = `~lo` + 1, saving carry.
  - FIX_HI: `hi` = `~hi` + carry.
- DIV:
  - FIX_LO negates the quotient when `pneg`.
  - FIX_HI negates the remainder when `rneg`.
- Otherwise both states hold.

**DONE:** one cycle, `done`=1. Next state is IDLE, or ABS_A if `start` is accepted.

**Arithmetic rules:**
- All results wrap modulo 2^32.
- Signed `0x80000000` / `-1` gives `lo`=`0x80000000`, `hi`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Latency: accept edge = edge 0.
  - ABS_A = edge 1, ABS_B = edge 2.
  - RUN = edges 3–34.
  - FIX_LO = 35, FIX_HI = 36.
  - `done` is high during the cycle after edge 36. Latency is 37 cycles.
- Divide-by-zero latency: `done` is high in the cycle after the accept edge.
- `busy` is high in ABS_A..FIX_HI. It is never high together with `done`.
- `hi`/`lo` change only inside an operation. They hold after `done` until the next accept.
- `err` clears at accept.
- `clr` mid-operation aborts immediately and all outputs take reset values. No `done` is issued.
- Back-to-back: `start` during DONE is accepted, so operations issue every 37 cycles.

## Configuration
- `MULDIV_DIV_EN` defined: DIV is supported as described.
- `MULDIV_DIV_EN` undefined:
  - No divide logic is built.
  - Any DIV accept goes directly to DONE with `err`=1 and `hi`=`lo`=0.
  - MUL behaviour is unchanged.

## Test plan
- Unsigned MUL `a`=`0xFFFFFFFF`, `b`=`0xFFFFFFFF` → `done` 37 cycles after accept, `hi`=`0xFFFFFFFE`, `lo`=`0x00000001`, `err`=0.
- Signed MUL `a`=-3, `b`=7 → `hi`=`0xFFFFFFFF`, `lo`=`0xFFFFFFEB`.
- Signed DIV `a`=-7, `b`=2 → `lo`=`0xFFFFFFFD`, `hi`=`0xFFFFFFFF`. Unsigned DIV `a`=`0xFFFFFFFF`, `b`=`0x80000000` → `lo`=1, `hi`=`0x7FFFFFFF`.
- DIV `a`=`0x1234`, `b`=0 → `done` 1 cycle after accept, `err`=1, `lo`=`0xFFFFFFFF`, `hi`=`0x1234`.
- `clr` pulsed 20 cycles into a MUL → `busy`/`hi`/`lo` = 0 immediately, no `done`. A new `start` then completes normally. `start` pulses while `busy` are ignored.
- Build without `MULDIV_DIV_EN`: DIV 10/3 → `err`=1, `hi`=`lo`=0, `done` 1 cycle after accept. MUL 6×7 → `lo`=42.
